// File: rtl/alu_decode_pkg.sv
// alu_decode_pkg: shared constants for the decode/execute datapath core.
//   - opcode and R-type funct field values
//   - 4-bit ALUControl codes
//   - bit positions inside the 12-bit control word
//     {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg,
//      Jump, Pop, Push, Bne, Jal, Jr}, MSB first
// Optional feature macro used by files importing this package: ALU_OVERFLOW_EN
package alu_decode_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_PUSH  = 6'h38;
  localparam logic [5:0] OP_POP   = 6'h39;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALUControl codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Control word layout
  localparam int unsigned CTRL_W       = 12;
  localparam int unsigned CB_REG_WRITE = 11;
  localparam int unsigned CB_REG_DST   = 10;
  localparam int unsigned CB_ALU_SRC   = 9;
  localparam int unsigned CB_BRANCH    = 8;
  localparam int unsigned CB_MEM_WRITE = 7;
  localparam int unsigned CB_MEM_TO_REG= 6;
  localparam int unsigned CB_JUMP      = 5;
  localparam int unsigned CB_POP       = 4;
  localparam int unsigned CB_PUSH      = 3;
  localparam int unsigned CB_BNE       = 2;
  localparam int unsigned CB_JAL       = 1;
  localparam int unsigned CB_JR        = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  // One-hot mask for a single control bit; OR several together to build a word.
  function automatic ctrl_t cbit(input int unsigned idx);
    return ctrl_t'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU driven by a 4-bit ALUControl code.
// Ports:
//   alu_a, alu_b : operands (WIDTH bits)
//   ctrl         : ALUControl code
//   result       : ALU result; undefined codes give 0
//   ovf          : signed overflow for ADD/SUB (only when ALU_OVERFLOW_EN is defined)
// Shifts use alu_b[4:0] as the amount with zero fill; SLT is a signed compare.
module alu_core
  import alu_decode_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       ctrl,
`ifdef ALU_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [4:0]       shamt;

  assign sum   = alu_a + alu_b;
  assign diff  = alu_a - alu_b;
  assign shamt = alu_b[4:0];

  always_comb begin
    result = '0;
    unique case (ctrl)
      ALU_AND: result = alu_a & alu_b;
      ALU_OR:  result = alu_a | alu_b;
      ALU_ADD: result = sum;
      ALU_XOR: result = alu_a ^ alu_b;
      ALU_SLL: result = alu_a << shamt;
      ALU_SRL: result = alu_a >> shamt;
      ALU_SUB: result = diff;
      ALU_SLT: result = WIDTH'($signed(alu_a) < $signed(alu_b));
      ALU_NOR: result = ~(alu_a | alu_b);
      default: result = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  // Overflow: the result sign contradicts what the operand signs allow.
  always_comb begin
    ovf = 1'b0;
    if (ctrl == ALU_ADD)
      ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
    else if (ctrl == ALU_SUB)
      ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
  end
`endif

endmodule

// File: rtl/alu_decode_unit.sv
// alu_decode_unit: decode/execute datapath core.
//   Decode : main controller (opcode/funct -> control word + ALUControl),
//            rs/rt equality comparator and beq/bne branch resolution.
//   Execute: ALU (alu_core) with its result registered at the EX/MEM boundary.
// Ports:
//   clk, rst (sync, active-low), en (result register load enable)
//   instr, cmp_a, cmp_b               : Decode inputs
//   alu_a, alu_b, alu_ctrl_in         : Execute inputs
//   ctrl, alu_ctrl, equal, pc_src     : combinational Decode outputs
//   alu_out                           : combinational ALU result
//   alu_q, zero_q                     : registered result and zero flag
//   ovf_q                             : registered overflow (only with ALU_OVERFLOW_EN)
// Optional feature macro: ALU_OVERFLOW_EN
module alu_decode_unit
  import alu_decode_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] cmp_a,
  input  logic [WIDTH-1:0] cmp_b,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alu_ctrl_in,
  output logic [11:0]      ctrl,
  output logic [3:0]       alu_ctrl,
  output logic             equal,
  output logic             pc_src,
  output logic [WIDTH-1:0] alu_out,
`ifdef ALU_OVERFLOW_EN
  output logic             ovf_q,
`endif
  output logic [WIDTH-1:0] alu_q,
  output logic             zero_q
);

  logic [5:0] opcode;
  logic [5:0] funct;
  ctrl_t      ctrl_next;
  logic [3:0] alu_ctrl_next;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Register/immediate fields are consumed elsewhere in the pipeline.
  logic unused_fields;
  assign unused_fields = ^instr[25:6];

  // ---------------- Main controller ----------------
  always_comb begin
    ctrl_next     = '0;
    alu_ctrl_next = ALU_ADD;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl_next = cbit(CB_REG_WRITE) | cbit(CB_REG_DST);
        unique case (funct)
          FN_ADD: alu_ctrl_next = ALU_ADD;
          FN_SUB: alu_ctrl_next = ALU_SUB;
          FN_AND: alu_ctrl_next = ALU_AND;
          FN_OR:  alu_ctrl_next = ALU_OR;
          FN_XOR: alu_ctrl_next = ALU_XOR;
          FN_NOR: alu_ctrl_next = ALU_NOR;
          FN_SLT: alu_ctrl_next = ALU_SLT;
          FN_SLL: alu_ctrl_next = ALU_SLL;
          FN_SRL: alu_ctrl_next = ALU_SRL;
          // jr writes nothing back; only the Jr control is raised.
          FN_JR:  ctrl_next = cbit(CB_JR);
          default: ctrl_next = '0;
        endcase
      end
      OP_LW:   ctrl_next = cbit(CB_REG_WRITE) | cbit(CB_ALU_SRC) | cbit(CB_MEM_TO_REG);
      OP_SW:   ctrl_next = cbit(CB_ALU_SRC) | cbit(CB_MEM_WRITE);
      OP_ADDI: ctrl_next = cbit(CB_REG_WRITE) | cbit(CB_ALU_SRC);
      OP_BEQ: begin
        ctrl_next     = cbit(CB_BRANCH);
        alu_ctrl_next = ALU_SUB;
      end
      OP_BNE: begin
        ctrl_next     = cbit(CB_BRANCH) | cbit(CB_BNE);
        alu_ctrl_next = ALU_SUB;
      end
      OP_J:    ctrl_next = cbit(CB_JUMP);
      OP_JAL:  ctrl_next = cbit(CB_JUMP) | cbit(CB_JAL) | cbit(CB_REG_WRITE);
      OP_PUSH: ctrl_next = cbit(CB_PUSH) | cbit(CB_ALU_SRC);
      OP_POP:  ctrl_next = cbit(CB_POP) | cbit(CB_REG_WRITE) | cbit(CB_ALU_SRC)
                         | cbit(CB_MEM_TO_REG);
      default: ctrl_next = '0;
    endcase
  end

  assign ctrl     = ctrl_next;
  assign alu_ctrl = alu_ctrl_next;

  // ---------------- Comparator / branch resolution ----------------
  logic [WIDTH-1:0] bit_match;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cmp
      assign bit_match[gi] = cmp_a[gi] ~^ cmp_b[gi];
    end
  endgenerate

  assign equal  = &bit_match;
  assign pc_src = ctrl_next[CB_BRANCH] & (ctrl_next[CB_BNE] ? ~equal : equal);

  // ---------------- Execute ALU ----------------
`ifdef ALU_OVERFLOW_EN
  logic ovf_next;
`endif

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .ctrl   (alu_ctrl_in),
`ifdef ALU_OVERFLOW_EN
    .ovf    (ovf_next),
`endif
    .result (alu_out)
  );

  // ---------------- EX/MEM result register ----------------
  logic [WIDTH-1:0] alu_q_reg;
  logic             zero_q_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_q_reg  <= '0;
      zero_q_reg <= 1'b1;
    end else if (en) begin
      alu_q_reg  <= alu_out;
      zero_q_reg <= (alu_out == '0);
    end
  end

  assign alu_q  = alu_q_reg;
  assign zero_q = zero_q_reg;

`ifdef ALU_OVERFLOW_EN
  logic ovf_q_reg;

  always_ff @(posedge clk) begin
    if (!rst)
      ovf_q_reg <= 1'b0;
    else if (en)
      ovf_q_reg <= ovf_next;
  end

  assign ovf_q = ovf_q_reg;
`endif

endmodule

// File: tb/tb_alu_decode_unit.sv
// tb_alu_decode_unit: self-checking bench for alu_decode_unit (WIDTH=32).
// Directed corner cases plus $urandom stimulus checked against a reference
// model built from the instruction table and plain integer arithmetic.
// Optional feature macro: ALU_OVERFLOW_EN (adds ovf_q checks).
module tb_alu_decode_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] instr;
  logic [31:0] cmp_a, cmp_b;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl_in;
  logic [11:0] ctrl;
  logic [3:0]  alu_ctrl;
  logic        equal, pc_src;
  logic [31:0] alu_out, alu_q;
  logic        zero_q;
`ifdef ALU_OVERFLOW_EN
  logic        ovf_q;
`endif

  int vectors;
  int miscompares;

  // Expected register state, advanced by the bench on each edge.
  logic [31:0] exp_q;
  logic        exp_z;
  logic        exp_o;

  alu_decode_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .instr       (instr),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl_in (alu_ctrl_in),
    .ctrl        (ctrl),
    .alu_ctrl    (alu_ctrl),
    .equal       (equal),
    .pc_src      (pc_src),
    .alu_out     (alu_out),
`ifdef ALU_OVERFLOW_EN
    .ovf_q       (ovf_q),
`endif
    .alu_q       (alu_q),
    .zero_q      (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- Reference model ----------------
  // Control word/ALUControl straight from the instruction table.
  function automatic logic [15:0] model_decode(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: case (fn)
        6'h20: return {12'b1100_0000_0000, 4'b0010};
        6'h22: return {12'b1100_0000_0000, 4'b0110};
        6'h24: return {12'b1100_0000_0000, 4'b0000};
        6'h25: return {12'b1100_0000_0000, 4'b0001};
        6'h26: return {12'b1100_0000_0000, 4'b0011};
        6'h27: return {12'b1100_0000_0000, 4'b1100};
        6'h2A: return {12'b1100_0000_0000, 4'b0111};
        6'h00: return {12'b1100_0000_0000, 4'b0100};
        6'h02: return {12'b1100_0000_0000, 4'b0101};
        6'h08: return {12'b0000_0000_0001, 4'b0010};
        default: return {12'b0, 4'b0010};
      endcase
      6'h23: return {12'b1010_0100_0000, 4'b0010};
      6'h2B: return {12'b0010_1000_0000, 4'b0010};
      6'h08: return {12'b1010_0000_0000, 4'b0010};
      6'h04: return {12'b0001_0000_0000, 4'b0110};
      6'h05: return {12'b0001_0000_0100, 4'b0110};
      6'h02: return {12'b0000_0010_0000, 4'b0010};
      6'h03: return {12'b1000_0010_0010, 4'b0010};
      6'h38: return {12'b0010_0000_1000, 4'b0010};
      6'h39: return {12'b1010_0101_0000, 4'b0010};
      default: return {12'b0, 4'b0010};
    endcase
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    int unsigned sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return 32'(sa + sb);
      4'b0011: return a ^ b;
      4'b0100: return 32'(longint'(a) * (longint'(1) << sh));
      4'b0101: return 32'(longint'(a) / (longint'(1) << sh));
      4'b0110: return 32'(sa - sb);
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Overflow: the exact signed result does not fit in 32 bits.
  function automatic logic model_ovf(input logic [3:0] c, input logic [31:0] a,
                                     input logic [31:0] b);
    longint r;
    if (c == 4'b0010)      r = longint'($signed(a)) + longint'($signed(b));
    else if (c == 4'b0110) r = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Advance expected register state by one clock edge.
  task automatic model_edge();
    if (!rst) begin
      exp_q = 32'd0; exp_z = 1'b1; exp_o = 1'b0;
    end else if (en) begin
      exp_q = model_alu(alu_ctrl_in, alu_a, alu_b);
      exp_z = (exp_q == 32'd0);
      exp_o = model_ovf(alu_ctrl_in, alu_a, alu_b);
    end
  endtask

  // Clock one edge, update the model, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b1; alu_a = 32'd5; alu_b = 32'd3; alu_ctrl_in = 4'b0010;
    step();
    step();
    vectors++;
    if (alu_q !== 32'd0) begin
      miscompares++; $display("FAIL reset_alu_q: got %h want %h", alu_q, 32'd0);
    end
    vectors++;
    if (zero_q !== 1'b1) begin
      miscompares++; $display("FAIL reset_zero_q: got %b want 1", zero_q);
    end
`ifdef ALU_OVERFLOW_EN
    vectors++;
    if (ovf_q !== 1'b0) begin
      miscompares++; $display("FAIL reset_ovf_q: got %b want 0", ovf_q);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    step();
    vectors++;
    if (alu_q !== 32'd8 || zero_q !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_load: got q=%h z=%b want q=%h z=0", alu_q, zero_q, 32'd8);
    end
    $display("reset: alu_q=%h zero_q=%b", alu_q, zero_q);
  endtask

  task automatic test_decode();
    logic [31:0] vec [2];
    logic [11:0] want_ctrl [2];
    logic [15:0] m;
    vec[0] = 32'h8C220004; want_ctrl[0] = 12'b101001000000;
    vec[1] = 32'h0C000010; want_ctrl[1] = 12'b100000100010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      instr = vec[i];
      #1;
      vectors++;
      if (ctrl !== want_ctrl[i]) begin
        miscompares++;
        $display("FAIL decode_ctrl instr=%h: got %b want %b", instr, ctrl, want_ctrl[i]);
      end
      $display("decode: instr=%h ctrl=%b alu_ctrl=%b", instr, ctrl, alu_ctrl);
    end
    instr = vec[0];
    #1;
    vectors++;
    if (alu_ctrl !== 4'b0010) begin
      miscompares++; $display("FAIL decode_lw_aluctrl: got %b want 0010", alu_ctrl);
    end
  endtask

  task automatic test_decode_random();
    logic [5:0] ops [11];
    logic [5:0] fns [11];
    logic [5:0] op, fn;
    logic [19:0] mid;
    logic [15:0] m;
    ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h03, 6'h38, 6'h39};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h08, 6'h3F};
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      op  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
      fn  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 10)];
      mid = 20'($urandom);
      instr = {op, mid, fn};
      #1;
      m = model_decode(instr);
      vectors++;
      if (ctrl !== m[15:4] || alu_ctrl !== m[3:0]) begin
        miscompares++;
        $display("FAIL decode_rand instr=%h: got ctrl=%b alu=%b want ctrl=%b alu=%b",
                 instr, ctrl, alu_ctrl, m[15:4], m[3:0]);
      end
      $display("decode_rand: instr=%h ctrl=%b alu_ctrl=%b", instr, ctrl, alu_ctrl);
    end
  endtask

  task automatic test_branch();
    logic [31:0] cb [2];
    logic        want [2];
    cb[0] = 32'd7; want[0] = 1'b0;
    cb[1] = 32'd6; want[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      instr = 32'h14220003; cmp_a = 32'd7; cmp_b = cb[i];
      #1;
      vectors++;
      if (equal !== (cb[i] == 32'd7) || pc_src !== want[i]) begin
        miscompares++;
        $display("FAIL bne_branch cmp_b=%0d: got eq=%b pc_src=%b want eq=%b pc_src=%b",
                 cb[i], equal, pc_src, (cb[i] == 32'd7), want[i]);
      end
      $display("branch: bne a=%0d b=%0d equal=%b pc_src=%b", cmp_a, cmp_b, equal, pc_src);
    end
  endtask

  task automatic test_branch_random();
    logic [5:0]  ops [4];
    logic [15:0] m;
    logic        eq, want_pc;
    ops = '{6'h04, 6'h05, 6'h00, 6'h23};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      instr = {ops[$urandom_range(0, 3)], 20'($urandom), 6'h20};
      cmp_a = $urandom;
      // Equal half the time; otherwise flip one random bit for a near miss.
      cmp_b = ($urandom_range(0, 1) == 1) ? cmp_a : (cmp_a ^ (32'd1 << $urandom_range(0, 31)));
      #1;
      m = model_decode(instr);
      eq = (cmp_a == cmp_b);
      want_pc = m[15:4][8] && (m[15:4][2] ? !eq : eq);
      vectors++;
      if (equal !== eq || pc_src !== want_pc) begin
        miscompares++;
        $display("FAIL branch_rand instr=%h a=%h b=%h: got eq=%b pc=%b want eq=%b pc=%b",
                 instr, cmp_a, cmp_b, equal, pc_src, eq, want_pc);
      end
      $display("branch_rand: instr=%h a=%h b=%h equal=%b pc_src=%b",
               instr, cmp_a, cmp_b, equal, pc_src);
    end
  endtask

  task automatic test_alu_corners();
    logic [3:0]  c [6];
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [31:0] want [6];
    c[0] = 4'b0110; a[0] = 32'd0;          b[0] = 32'd1;          want[0] = 32'hFFFFFFFF;
    c[1] = 4'b0111; a[1] = 32'hFFFFFFFF;   b[1] = 32'd1;          want[1] = 32'd1;
    c[2] = 4'b0100; a[2] = 32'd1;          b[2] = 32'd31;         want[2] = 32'h80000000;
    c[3] = 4'b0101; a[3] = 32'h80000000;   b[3] = 32'd31;         want[3] = 32'd1;
    c[4] = 4'b1100; a[4] = 32'd0;          b[4] = 32'd0;          want[4] = 32'hFFFFFFFF;
    c[5] = 4'b1111; a[5] = 32'h12345678;   b[5] = 32'h9ABCDEF0;   want[5] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en = 1'b1; alu_ctrl_in = c[i]; alu_a = a[i]; alu_b = b[i];
      #1;
      vectors++;
      if (alu_out !== want[i]) begin
        miscompares++;
        $display("FAIL alu_corner ctrl=%b a=%h b=%h: got %h want %h",
                 c[i], a[i], b[i], alu_out, want[i]);
      end
      step();
      vectors++;
      if (alu_q !== want[i] || zero_q !== (want[i] == 32'd0)) begin
        miscompares++;
        $display("FAIL alu_corner_reg ctrl=%b: got q=%h z=%b want q=%h z=%b",
                 c[i], alu_q, zero_q, want[i], (want[i] == 32'd0));
      end
      $display("alu_corner: ctrl=%b a=%h b=%h out=%h q=%h", c[i], a[i], b[i], alu_out, alu_q);
    end
  endtask

  task automatic test_alu_random();
    logic [31:0] want;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      alu_ctrl_in = 4'($urandom);
      alu_a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      alu_b = ($urandom_range(0, 7) == 0) ? alu_a : $urandom;
      en    = ($urandom_range(0, 3) != 0);
      #1;
      want = model_alu(alu_ctrl_in, alu_a, alu_b);
      vectors++;
      if (alu_out !== want) begin
        miscompares++;
        $display("FAIL alu_rand ctrl=%b a=%h b=%h: got %h want %h",
                 alu_ctrl_in, alu_a, alu_b, alu_out, want);
      end
      step();
      vectors++;
      if (alu_q !== exp_q || zero_q !== exp_z) begin
        miscompares++;
        $display("FAIL alu_rand_reg en=%b: got q=%h z=%b want q=%h z=%b",
                 en, alu_q, zero_q, exp_q, exp_z);
      end
`ifdef ALU_OVERFLOW_EN
      vectors++;
      if (ovf_q !== exp_o) begin
        miscompares++;
        $display("FAIL alu_rand_ovf ctrl=%b a=%h b=%h: got %b want %b",
                 alu_ctrl_in, alu_a, alu_b, ovf_q, exp_o);
      end
`endif
      $display("alu_rand: ctrl=%b a=%h b=%h en=%b out=%h q=%h z=%b",
               alu_ctrl_in, alu_a, alu_b, en, alu_out, alu_q, zero_q);
    end
  endtask

  task automatic test_enable_hold();
    @(negedge clk);
    en = 1'b1; alu_ctrl_in = 4'b0010; alu_a = 32'd40; alu_b = 32'd2;
    step();
    @(negedge clk);
    en = 1'b0; alu_a = 32'd0; alu_b = 32'd0;   // alu_out now 0
    step();
    step();
    vectors++;
    if (alu_q !== 32'd42 || zero_q !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_hold: got q=%h z=%b want q=%h z=0", alu_q, zero_q, 32'd42);
    end
    $display("enable_hold: q=%h z=%b", alu_q, zero_q);
    @(negedge clk);
    rst = 1'b0;
    step();
    vectors++;
    if (alu_q !== 32'd0 || zero_q !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_with_en0: got q=%h z=%b want q=0 z=1", alu_q, zero_q);
    end
    $display("reset_with_en0: q=%h z=%b", alu_q, zero_q);
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifdef ALU_OVERFLOW_EN
  task automatic test_overflow();
    logic [3:0]  c [3];
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic        want [3];
    c[0] = 4'b0010; a[0] = 32'h7FFFFFFF; b[0] = 32'd1; want[0] = 1'b1;
    c[1] = 4'b0110; a[1] = 32'h80000000; b[1] = 32'd1; want[1] = 1'b1;
    c[2] = 4'b0000; a[2] = $urandom;     b[2] = $urandom; want[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b1; alu_ctrl_in = c[i]; alu_a = a[i]; alu_b = b[i];
      step();
      vectors++;
      if (ovf_q !== want[i]) begin
        miscompares++;
        $display("FAIL overflow ctrl=%b a=%h b=%h: got %b want %b", c[i], a[i], b[i],
                 ovf_q, want[i]);
      end
      $display("overflow: ctrl=%b a=%h b=%h ovf_q=%b", c[i], a[i], b[i], ovf_q);
    end
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; en = 1'b0; instr = 32'd0;
    cmp_a = 32'd0; cmp_b = 32'd0; alu_a = 32'd0; alu_b = 32'd0; alu_ctrl_in = 4'b0010;
    exp_q = 32'd0; exp_z = 1'b1; exp_o = 1'b0;
    test_reset();
    test_decode();
    test_decode_random();
    test_branch();
    test_branch_random();
    test_alu_corners();
    test_alu_random();
    test_enable_hold();
`ifdef ALU_OVERFLOW_EN
    test_overflow();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
